sysahb_apb_bridge: RTL
======================

# sysahb_apb_bridge

AHB-Lite slave to APB (APB4-style with PSTRB) bridge. It occupies the spare HSEL2 slot of the system AHB slave multiplexer and converts each selected AHB transfer into one APB SETUP/ACCESS transaction. It then returns the completion to the AHB side with the correct HREADYOUT/HRESP/HRDATA timing. It is the gateway to all low-speed peripherals (UART, timer, GPIO) on the system bus.

## Interface
Parameters:
- AWIDTH, 16, number of HADDR bits forwarded to PADDR.
- TIMEOUT, 255, APB ACCESS-phase cycle limit. Only used with SYSAHB_APB_TIMEOUT_EN.

Ports:
- sys_clk  in  1  single clock for both AHB and APB sides.
- sys_resetn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HREADY  in  1  bus HREADY, from the mux output.
- HTRANS  in  2  transfer type.
- HSIZE  in  2  transfer size, 0=byte, 1=half, 2=word.
- HWRITE  in  1  write flag.
- HADDR  in  AWIDTH  address.
- HWDATA  in  32  write data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  error response.
- HRDATA  out  32  read data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AWIDTH  APB address, with bits [1:0] forced to 0.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  byte strobes. Derived from HSIZE/HADDR[1:0] on writes; 0 on reads.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

## Operation
- Accept: a transfer is accepted when HSEL & HREADY & HTRANS[1] is sampled on a rising edge. On acceptance the bridge registers HADDR, HWRITE and the strobes. IDLE/BUSY transfers are never accepted.
- FSM states: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE:
  - HREADYOUT=1, HRESP=0, PSEL=0.
  - Accepted write goes to WDATA; accepted read goes to SETUP.
- WDATA:
  - HREADYOUT=0.
  - Captures HWDATA into PWDATA at the end of the cycle.
  - Next state is SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, HREADYOUT=0.
  - Next state is ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, HREADYOUT=0.
  - Holds while PREADY=0.
  - PREADY=1 & PSLVERR=0: go to DONE; on a read, capture PRDATA into HRDATA.
  - PREADY=1 & PSLVERR=1: go to ERR1; HRDATA is loaded with 0.
- DONE:
  - HREADYOUT=1, HRESP=0, PSEL=0.
  - Acceptance is checked in this cycle, exactly as in IDLE. This gives back-to-back pipelining.
  - With no acceptance, the next state is IDLE.
- ERR1: HREADYOUT=0, HRESP=1, PSEL=0. Next state is ERR2.
- ERR2:
  - HREADYOUT=1, HRESP=1.
  - Acceptance is checked as in IDLE.
  - If the master cancels the next transfer with HTRANS=IDLE, no APB access follows.
- Address and control stability: PADDR, PWRITE, PSTRB and PWDATA are stable from SETUP through the final ACCESS cycle. PSEL is never asserted outside SETUP/ACCESS.
- PSTRB generation for writes:
  - Byte: one-hot on HADDR[1:0].
  - Half: 4'b0011 or 4'b1100, selected by HADDR[1].
  - Word: 4'b1111.
- HRDATA holds its last value outside DONE.
- Reset (asserted at any time, including mid-transaction):
  - State goes to IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0.
  - Timeout counter cleared.

## Timing
- All outputs are registered, or decoded directly from the registered state.
- Read, zero-wait APB: address phase at T0; SETUP T1; ACCESS T2; DONE T3. This gives 2 AHB wait states, with HRDATA valid in T3.
- Write, zero-wait APB: WDATA T1; SETUP T2; ACCESS T3; DONE T4. This gives 3 AHB wait states.
- Each APB wait cycle (PREADY=0) adds exactly one AHB wait state.
- Error response takes two cycles, ERR1 then ERR2, with HRESP=1 in both. HREADYOUT is 0 then 1.

## Configuration
- SYSAHB_APB_TIMEOUT_EN defined:
  - An 8+ bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - If the counter reaches TIMEOUT, PSEL and PENABLE are dropped and the FSM goes to ERR1. HRDATA is loaded with 0.
  - A late PREADY from the peripheral is ignored.
- Undefined:
  - No counter is present.
  - ACCESS waits on PREADY indefinitely.

## Test plan
- Word write 0xDEADBEEF to 0x0010, zero-wait slave:
  - PSEL high T2–T3 and PENABLE high T3.
  - PADDR=0x0010, PWDATA=0xDEADBEEF, PSTRB=4'hF, PWRITE=1.
  - HREADYOUT=1 in T4.
- Read from 0x0024 with PRDATA=0x12345678 and PREADY low for 3 ACCESS cycles:
  - HREADYOUT low for 5 cycles.
  - HRDATA=0x12345678 when HREADYOUT returns high.
- Byte write to 0x0003 then halfword write to 0x0006, issued back-to-back:
  - PSTRB=4'b1000, then PSTRB=4'b1100.
  - The second SETUP begins with no IDLE cycle between the two transfers.
- Read with PSLVERR=1 at PREADY: HRESP=1 for two cycles with HREADYOUT 0 then 1, and HRDATA=0.
- Timeout with SYSAHB_APB_TIMEOUT_EN and TIMEOUT=4: PREADY is held at 0, so PSEL drops after 4 ACCESS cycles, followed by the ERR1/ERR2 response.
- sys_resetn pulsed low during ACCESS: all outputs return to reset values immediately, and the next accepted transfer completes normally.

Source files
------------

// File: rtl/sysahb_apb_bridge.sv
// ----------------------------------------------------------------------------
// sysahb_apb_bridge
//
// AHB-Lite slave to APB4 bridge for the HSEL2 slot of the system AHB slave
// multiplexer. Each accepted AHB transfer becomes exactly one APB SETUP/ACCESS
// transaction. The completion, error or read data is then returned with
// registered HREADYOUT/HRESP/HRDATA.
//
// Optional feature (compile-time macro): SYSAHB_APB_TIMEOUT_EN
//   When defined, an ACCESS-phase watchdog aborts a transfer after TIMEOUT
//   ACCESS cycles with PREADY low. The abort gives an AHB error response, and
//   a late PREADY is ignored. When undefined, ACCESS waits on PREADY forever.
//
// Parameters
//   AWIDTH   HADDR bits forwarded to PADDR (>= 3)
//   TIMEOUT  ACCESS-cycle limit, used only with SYSAHB_APB_TIMEOUT_EN
//
// Ports
//   sys_clk, sys_resetn        clock, async active-low reset
//   HSEL HREADY HTRANS HSIZE   AHB address-phase control
//   HWRITE HADDR HWDATA        AHB address/data
//   HREADYOUT HRESP HRDATA     AHB response (decoded from state / registered)
//   PSEL PENABLE PWRITE        APB control (PSEL/PENABLE decoded from state)
//   PADDR PWDATA PSTRB         APB address/data/strobes (registered)
//   PRDATA PREADY PSLVERR      APB completer response
// ----------------------------------------------------------------------------
module sysahb_apb_bridge #(
  parameter int AWIDTH  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [1:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // state  | meaning
  // -------+-----------------------------------------------------------------
  // IDLE   | no transfer in flight; AHB ready, may accept
  // WDATA  | write data phase: AHB wait, HWDATA captured into PWDATA
  // SETUP  | APB setup phase (PSEL=1, PENABLE=0)
  // ACCESS | APB access phase (PSEL=1, PENABLE=1), holds while PREADY=0
  // DONE   | OKAY completion cycle, HRDATA valid for reads; may accept
  // ERR1   | first error cycle (HRESP=1, HREADYOUT=0)
  // ERR2   | second error cycle (HRESP=1, HREADYOUT=1); may accept
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_paddr;
  logic              r_pwrite;
  logic [3:0]        r_pstrb;
  logic [31:0]       r_pwdata;
  logic [31:0]       r_hrdata;

  logic              w_accept_slot;
  logic              w_accept;
  logic [3:0]        w_strb;
  logic              w_unused;

`ifdef SYSAHB_APB_TIMEOUT_EN
  // At least 8 bits, wider if TIMEOUT needs it.
  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              w_tmo_hit;

  // The counter holds the number of ACCESS cycles already spent with PREADY
  // low. The current stalled cycle is the TIMEOUT-th when it equals
  // TIMEOUT-1.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif

  // The bridge can accept only when its own HREADYOUT is high.
  assign w_accept_slot = (r_state == S_IDLE) || (r_state == S_DONE) ||
                         (r_state == S_ERR2);
  assign w_accept      = w_accept_slot && HSEL && HREADY && HTRANS[1];

  // Write strobes from size and low address bits. Size 3 is not used by
  // the system masters and is treated as a word.
  always_comb begin
    w_strb = 4'b0000;
    case (HSIZE)
      2'b00:   w_strb = 4'b0001 << HADDR[1:0];
      2'b01:   w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  // SEQ and NONSEQ are handled the same way, so HTRANS[0] is not needed.
  assign w_unused = HTRANS[0] | (TIMEOUT == 0);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state   <= S_IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= 4'b0000;
      r_pwdata  <= 32'h0;
      r_hrdata  <= 32'h0;
`ifdef SYSAHB_APB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (w_accept) begin
            r_paddr  <= {HADDR[AWIDTH-1:2], 2'b00};
            r_pwrite <= HWRITE;
            r_pstrb  <= HWRITE ? w_strb : 4'b0000;
            r_state  <= HWRITE ? S_WDATA : S_SETUP;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        S_WDATA: begin
          r_pwdata <= HWDATA;
          r_state  <= S_SETUP;
        end

        S_SETUP: begin
`ifdef SYSAHB_APB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          r_state <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              r_hrdata <= 32'h0;
              r_state  <= S_ERR1;
            end else begin
              if (!r_pwrite) begin
                r_hrdata <= PRDATA;
              end
              r_state <= S_DONE;
            end
          end
`ifdef SYSAHB_APB_TIMEOUT_EN
          // Leaving ACCESS drops PSEL/PENABLE. A PREADY arriving later is
          // never seen because ERR1/ERR2 do not look at the APB side.
          else if (w_tmo_hit) begin
            r_hrdata <= 32'h0;
            r_state  <= S_ERR1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end

        S_ERR1: begin
          r_state <= S_ERR2;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign HREADYOUT = w_accept_slot;
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = r_hrdata;
  assign PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE   = (r_state == S_ACCESS);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

endmodule
